// File: rtl/hazard_stall_controller_pkg.sv
// Shared pipeline definitions for the hazard/stall controller and its mult/div tracker.
package hazard_stall_controller_pkg;

    localparam int unsigned REG_W    = 5;
    localparam int unsigned MD_CNT_W = 8;

    // Mult/div occupancy states
    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_BUSY = 2'b01,
        MD_DONE = 2'b10
    } md_state_e;

    // Architectural register $zero never creates a dependency
    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

    // Stall/flush control bundle driven into the front of the pipe
    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic id_ex_bubble;
        logic if_id_flush;
    } pipe_ctrl_t;

    localparam int unsigned CTRL_W = $bits(pipe_ctrl_t);

    // Control bundle for a cycle: a taken branch overrides any stall
    function automatic pipe_ctrl_t pipe_ctrl(input logic i_stall, input logic i_flush);
        pipe_ctrl_t c;
        c.pc_write     = 1'b1;
        c.if_id_write  = 1'b1;
        c.id_ex_bubble = 1'b0;
        c.if_id_flush  = 1'b0;
        if (i_flush) begin
            c.id_ex_bubble = 1'b1;
            c.if_id_flush  = 1'b1;
        end else if (i_stall) begin
            c.pc_write     = 1'b0;
            c.if_id_write  = 1'b0;
            c.id_ex_bubble = 1'b1;
        end
        return c;
    endfunction

endpackage

// File: rtl/hazard_stall_controller_muldiv_tracker.sv
// Tracks occupancy of the multi-cycle mult/div unit: IDLE -> BUSY (LAT cycles) -> DONE -> IDLE.
module muldiv_tracker
    import hazard_stall_controller_pkg::*;
#(
    parameter int unsigned MULDIV_LAT = 32
) (
    input  logic clk,
    input  logic reset,
    input  logic i_start,
    input  logic i_accept,
    output logic o_go,
    output logic o_busy
);

    localparam logic [MD_CNT_W-1:0] LOAD_VAL = MD_CNT_W'(MULDIV_LAT - 1);

    md_state_e           r_state;
    md_state_e           w_state_nxt;
    logic [MD_CNT_W-1:0] r_cnt;
    logic [MD_CNT_W-1:0] w_cnt_nxt;

    // State and remaining-cycle counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= MD_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next state, counter update and issue pulse; issued operations always run to completion
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        o_go        = 1'b0;
        case (r_state)
            MD_IDLE: begin
                if (i_start && i_accept) begin
                    o_go        = 1'b1;
                    w_cnt_nxt   = LOAD_VAL;
                    w_state_nxt = MD_BUSY;
                end
            end
            MD_BUSY: begin
                if (r_cnt == '0) begin
                    w_state_nxt = MD_DONE;
                end else begin
                    w_cnt_nxt = r_cnt - MD_CNT_W'(1);
                end
            end
            MD_DONE: begin
                w_state_nxt = MD_IDLE;
            end
            default: begin
                w_state_nxt = MD_IDLE;
            end
        endcase
    end

    assign o_busy = (r_state != MD_IDLE);

endmodule

// File: rtl/hazard_stall_controller.sv
// Load-use / HI-LO stall detection, branch flush priority and stall-cycle counter.
module hazard_stall_controller
    import hazard_stall_controller_pkg::*;
#(
    parameter int unsigned MULDIV_LAT = 32,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] IF_ID_RS,
    input  logic [REG_W-1:0] IF_ID_RT,
    input  logic             ID_USES_RT,
    input  logic [REG_W-1:0] ID_EX_RT,
    input  logic             ID_EX_MEMREAD,
    input  logic             ID_MULDIV_START,
    input  logic             ID_READS_HILO,
    input  logic             BRANCH_TAKEN,
    output logic             PC_WRITE,
    output logic             IF_ID_WRITE,
    output logic             ID_EX_BUBBLE,
    output logic             IF_ID_FLUSH,
    output logic             MULDIV_GO,
    output logic             MULDIV_BUSY,
    output logic [CNT_W-1:0] STALL_COUNT
);

    logic             w_load_use;
    logic             w_muldiv_hz;
    logic             w_stall;
    logic             w_md_busy;
    logic             w_md_accept;
    pipe_ctrl_t       w_ctrl;
    logic [CNT_W-1:0] r_stall_count;

    // Hazard detection: load result not yet available, or HI/LO owned by an in-flight mult/div
    always_comb begin
        w_load_use  = ID_EX_MEMREAD && (ID_EX_RT != REG_ZERO) &&
                      ((ID_EX_RT == IF_ID_RS) || (ID_USES_RT && (ID_EX_RT == IF_ID_RT)));
        w_muldiv_hz = w_md_busy && (ID_READS_HILO || ID_MULDIV_START);
        w_stall     = (w_load_use || w_muldiv_hz) && !BRANCH_TAKEN;
        w_md_accept = !w_stall && !BRANCH_TAKEN;
        w_ctrl      = pipe_ctrl(w_stall, BRANCH_TAKEN);
    end

    muldiv_tracker #(
        .MULDIV_LAT (MULDIV_LAT)
    ) u_muldiv_tracker (
        .clk      (clk),
        .reset    (reset),
        .i_start  (ID_MULDIV_START),
        .i_accept (w_md_accept),
        .o_go     (MULDIV_GO),
        .o_busy   (w_md_busy)
    );

    // Saturating count of stalled cycles
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_count <= '0;
        end else if (w_stall && (r_stall_count != '1)) begin
            r_stall_count <= r_stall_count + CNT_W'(1);
        end
    end

    assign PC_WRITE     = w_ctrl.pc_write;
    assign IF_ID_WRITE  = w_ctrl.if_id_write;
    assign ID_EX_BUBBLE = w_ctrl.id_ex_bubble;
    assign IF_ID_FLUSH  = w_ctrl.if_id_flush;
    assign MULDIV_BUSY  = w_md_busy;
    assign STALL_COUNT  = r_stall_count;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed bench: dut_a (MULDIV_LAT=4, CNT_W=16) and dut_b (MULDIV_LAT=32, CNT_W=4) share stimulus.
module tb_hazard_stall_controller;

    logic       clk;
    logic       reset;
    logic [4:0] if_id_rs;
    logic [4:0] if_id_rt;
    logic       id_uses_rt;
    logic [4:0] id_ex_rt;
    logic       id_ex_memread;
    logic       id_muldiv_start;
    logic       id_reads_hilo;
    logic       branch_taken;

    logic        a_pc_write, a_if_id_write, a_bubble, a_flush, a_go, a_busy;
    logic [15:0] a_count;
    logic        b_pc_write, b_if_id_write, b_bubble, b_flush, b_go, b_busy;
    logic [3:0]  b_count;

    int n_checks = 0;
    int n_fail   = 0;

    hazard_stall_controller #(.MULDIV_LAT(4), .CNT_W(16)) dut_a (
        .clk             (clk),
        .reset           (reset),
        .IF_ID_RS        (if_id_rs),
        .IF_ID_RT        (if_id_rt),
        .ID_USES_RT      (id_uses_rt),
        .ID_EX_RT        (id_ex_rt),
        .ID_EX_MEMREAD   (id_ex_memread),
        .ID_MULDIV_START (id_muldiv_start),
        .ID_READS_HILO   (id_reads_hilo),
        .BRANCH_TAKEN    (branch_taken),
        .PC_WRITE        (a_pc_write),
        .IF_ID_WRITE     (a_if_id_write),
        .ID_EX_BUBBLE    (a_bubble),
        .IF_ID_FLUSH     (a_flush),
        .MULDIV_GO       (a_go),
        .MULDIV_BUSY     (a_busy),
        .STALL_COUNT     (a_count)
    );

    hazard_stall_controller #(.MULDIV_LAT(32), .CNT_W(4)) dut_b (
        .clk             (clk),
        .reset           (reset),
        .IF_ID_RS        (if_id_rs),
        .IF_ID_RT        (if_id_rt),
        .ID_USES_RT      (id_uses_rt),
        .ID_EX_RT        (id_ex_rt),
        .ID_EX_MEMREAD   (id_ex_memread),
        .ID_MULDIV_START (id_muldiv_start),
        .ID_READS_HILO   (id_reads_hilo),
        .BRANCH_TAKEN    (branch_taken),
        .PC_WRITE        (b_pc_write),
        .IF_ID_WRITE     (b_if_id_write),
        .ID_EX_BUBBLE    (b_bubble),
        .IF_ID_FLUSH     (b_flush),
        .MULDIV_GO       (b_go),
        .MULDIV_BUSY     (b_busy),
        .STALL_COUNT     (b_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs are then changed mid-cycle
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Let combinational outputs settle after an input change
    task automatic settle();
        #1;
    endtask

    task automatic clear_inputs();
        if_id_rs        = 5'd0;
        if_id_rt        = 5'd0;
        id_uses_rt      = 1'b0;
        id_ex_rt        = 5'd0;
        id_ex_memread   = 1'b0;
        id_muldiv_start = 1'b0;
        id_reads_hilo   = 1'b0;
        branch_taken    = 1'b0;
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        #12;
        settle();
        // Reset state
        chk("rst_pc_write", 32'(a_pc_write), 32'd1);
        chk("rst_if_id_write", 32'(a_if_id_write), 32'd1);
        chk("rst_bubble", 32'(a_bubble), 32'd0);
        chk("rst_flush", 32'(a_flush), 32'd0);
        chk("rst_go", 32'(a_go), 32'd0);
        chk("rst_busy", 32'(a_busy), 32'd0);
        chk("rst_count", 32'(a_count), 32'd0);
        reset = 1'b0;
        tick();

        // 1. Load-use on rs
        id_ex_memread = 1'b1; id_ex_rt = 5'd8; if_id_rs = 5'd8;
        settle();
        chk("lu_pc_write", 32'(a_pc_write), 32'd0);
        chk("lu_if_id_write", 32'(a_if_id_write), 32'd0);
        chk("lu_bubble", 32'(a_bubble), 32'd1);
        chk("lu_flush", 32'(a_flush), 32'd0);
        tick();
        chk("lu_count", 32'(a_count), 32'd1);
        id_ex_memread = 1'b0;
        settle();
        chk("lu_release_pc", 32'(a_pc_write), 32'd1);
        chk("lu_release_bubble", 32'(a_bubble), 32'd0);

        // 2. Register zero and unused rt
        id_ex_memread = 1'b1; id_ex_rt = 5'd0; if_id_rs = 5'd0;
        settle();
        chk("r0_pc_write", 32'(a_pc_write), 32'd1);
        id_ex_rt = 5'd9; if_id_rt = 5'd9; if_id_rs = 5'd3; id_uses_rt = 1'b0;
        settle();
        chk("rt_unused_pc_write", 32'(a_pc_write), 32'd1);
        tick();
        chk("nostall_count", 32'(a_count), 32'd1);
        id_uses_rt = 1'b1;
        settle();
        chk("rt_used_pc_write", 32'(a_pc_write), 32'd0);
        tick();
        chk("rt_used_count", 32'(a_count), 32'd2);
        clear_inputs();

        // 3. Mult/div issue, HI/LO read stalls until busy falls
        id_muldiv_start = 1'b1;
        settle();
        chk("md_go", 32'(a_go), 32'd1);
        chk("md_pc_write_at_go", 32'(a_pc_write), 32'd1);
        tick();
        id_muldiv_start = 1'b0; id_reads_hilo = 1'b1;
        settle();
        chk("md_go_pulse", 32'(a_go), 32'd0);
        for (int i = 1; i <= 5; i++) begin
            chk("md_busy", 32'(a_busy), 32'd1);
            chk("md_hilo_stall", 32'(a_pc_write), 32'd0);
            if (i < 5) tick();
        end
        tick();
        settle();
        chk("md_busy_fall", 32'(a_busy), 32'd0);
        chk("md_hilo_release", 32'(a_pc_write), 32'd1);
        chk("md_stall_count", 32'(a_count), 32'd7);
        id_reads_hilo = 1'b0;

        // 4. Branch priority over load-use and over mult/div issue
        id_ex_memread = 1'b1; id_ex_rt = 5'd8; if_id_rs = 5'd8; branch_taken = 1'b1;
        settle();
        chk("br_flush", 32'(a_flush), 32'd1);
        chk("br_bubble", 32'(a_bubble), 32'd1);
        chk("br_pc_write", 32'(a_pc_write), 32'd1);
        chk("br_if_id_write", 32'(a_if_id_write), 32'd1);
        tick();
        chk("br_count_held", 32'(a_count), 32'd7);
        id_ex_memread = 1'b0; id_muldiv_start = 1'b1;
        settle();
        chk("br_no_go", 32'(a_go), 32'd0);
        tick();
        chk("br_no_busy", 32'(a_busy), 32'd0);
        clear_inputs();

        // 5. Reset in the middle of a long mult/div
        reset = 1'b1;
        tick();
        reset = 1'b0;
        id_muldiv_start = 1'b1;
        settle();
        chk("rb_go_b", 32'(b_go), 32'd1);
        tick();
        id_muldiv_start = 1'b0; id_reads_hilo = 1'b1;
        for (int i = 0; i < 21; i++) tick();
        settle();
        chk("rb_busy_before", 32'(b_busy), 32'd1);
        chk("rb_count_b_sat", 32'(b_count), 32'd15);
        chk("rb_count_a", 32'(a_count), 32'd5);
        reset = 1'b1;
        settle();
        chk("rb_busy_async", 32'(b_busy), 32'd0);
        chk("rb_count_b_async", 32'(b_count), 32'd0);
        chk("rb_count_a_async", 32'(a_count), 32'd0);
        tick();
        reset = 1'b0;
        id_reads_hilo = 1'b0; id_muldiv_start = 1'b1;
        settle();
        chk("rb_reissue_go", 32'(b_go), 32'd1);
        tick();
        chk("rb_reissue_busy", 32'(b_busy), 32'd1);
        id_muldiv_start = 1'b0;

        // 6. Saturation of the 4-bit counter under a held load-use
        id_ex_memread = 1'b1; id_ex_rt = 5'd8; if_id_rs = 5'd8;
        settle();
        chk("sat_stall", 32'(b_pc_write), 32'd0);
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 14) chk("sat_count_14", 32'(b_count), 32'd14);
            if (i == 15) chk("sat_count_15", 32'(b_count), 32'd15);
        end
        chk("sat_count_held", 32'(b_count), 32'd15);
        chk("sat_count_wide", 32'(a_count), 32'd20);
        clear_inputs();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
